t01_ai_move_scheduler: RTL and testbench

Sequences the AI placement search for one falling piece. It walks every (rotation, column) candidate and has the placement generator build each candidate board. For each legal board it runs one handshake with t01_ai_feature_extract, scores the returned features with fixed weights, and keeps the best candidate. It sits between the game FSM (start/done) and the AI datapath (placement generator and feature extractor).

---
 rtl/t01_ai_pkg.sv | 28 ++
 rtl/t01_ai_score_calc.sv | 37 +++
 rtl/t01_ai_move_scheduler.sv | 177 +++++++++++++++++
 tb/tb_t01_ai_move_scheduler.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t01_ai_pkg.sv
// Shared types and constants for the AI placement search datapath.
// Holds the scheduler state encoding, datapath widths and default score weights.
package t01_ai_pkg;

    localparam int SCORE_W      = 16;
    localparam int ROT_W        = 2;
    localparam int COL_W        = 4;

    localparam int NUM_ROT_DEF  = 4;
    localparam int NUM_COL_DEF  = 10;
    localparam int W_LINES_DEF  = 8;
    localparam int W_HOLES_DEF  = 5;
    localparam int W_BUMP_DEF   = 1;
    localparam int W_HEIGHT_DEF = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ,
        S_START,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_SCORE,
        S_RELEASE,
        S_NEXT,
        S_DONE
    } state_e;

endpackage

// File: rtl/t01_ai_score_calc.sv
// Weighted board score from extractor features, plus the signed compare
// that decides whether this candidate replaces the current best.
module t01_ai_score_calc
    import t01_ai_pkg::*;
#(
    parameter int W_LINES  = W_LINES_DEF,
    parameter int W_HOLES  = W_HOLES_DEF,
    parameter int W_BUMP   = W_BUMP_DEF,
    parameter int W_HEIGHT = W_HEIGHT_DEF
) (
    input  logic        [2:0]         lines_cleared,
    input  logic        [7:0]         holes,
    input  logic        [7:0]         bumpiness,
    input  logic        [7:0]         height_sum,
    input  logic                      best_valid,
    input  logic signed [SCORE_W-1:0] best_score,
    output logic signed [SCORE_W-1:0] score,
    output logic                      better
);

    logic [SCORE_W-1:0] lines_term;
    logic [SCORE_W-1:0] holes_term;
    logic [SCORE_W-1:0] bump_term;
    logic [SCORE_W-1:0] height_term;

    // Features are zero-extended; the modulo-2^16 difference is the signed score.
    always_comb begin
        lines_term  = SCORE_W'(W_LINES)  * SCORE_W'(lines_cleared);
        holes_term  = SCORE_W'(W_HOLES)  * SCORE_W'(holes);
        bump_term   = SCORE_W'(W_BUMP)   * SCORE_W'(bumpiness);
        height_term = SCORE_W'(W_HEIGHT) * SCORE_W'(height_sum);
        score       = $signed(lines_term - holes_term - bump_term - height_term);
        // Strictly greater, so ties keep the earlier candidate.
        better      = !best_valid || (score > best_score);
    end

endmodule

// File: rtl/t01_ai_move_scheduler.sv
// Walks every (rotation, column) candidate, handshakes with the placement
// generator and feature extractor, and keeps the best-scoring placement.
module t01_ai_move_scheduler
    import t01_ai_pkg::*;
#(
    parameter int NUM_ROT  = NUM_ROT_DEF,
    parameter int NUM_COL  = NUM_COL_DEF,
    parameter int W_LINES  = W_LINES_DEF,
    parameter int W_HOLES  = W_HOLES_DEF,
    parameter int W_BUMP   = W_BUMP_DEF,
    parameter int W_HEIGHT = W_HEIGHT_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start_search,
    input  logic                      abort,
    output logic                      place_req,
    output logic        [ROT_W-1:0]   place_rot,
    output logic        [COL_W-1:0]   place_col,
    input  logic                      place_ack,
    input  logic                      place_legal,
    output logic                      start_extract,
    input  logic                      extract_ready,
    input  logic        [2:0]         lines_cleared,
    input  logic        [7:0]         holes,
    input  logic        [7:0]         bumpiness,
    input  logic        [7:0]         height_sum,
    output logic                      busy,
    output logic                      search_done,
    output logic                      best_valid,
    output logic        [ROT_W-1:0]   best_rot,
    output logic        [COL_W-1:0]   best_col,
    output logic signed [SCORE_W-1:0] best_score
);

    localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(NUM_ROT - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COL - 1);

    state_e                    state_q, state_d;
    logic        [ROT_W-1:0]   rot_q, rot_d;
    logic        [COL_W-1:0]   col_q, col_d;
    logic                      place_req_q, place_req_d;
    logic                      start_extract_q, start_extract_d;
    logic                      busy_q, busy_d;
    logic                      search_done_q, search_done_d;
    logic                      best_valid_q, best_valid_d;
    logic        [ROT_W-1:0]   best_rot_q, best_rot_d;
    logic        [COL_W-1:0]   best_col_q, best_col_d;
    logic signed [SCORE_W-1:0] best_score_q, best_score_d;

    logic signed [SCORE_W-1:0] score;
    logic                      better;

    t01_ai_score_calc #(
        .W_LINES  (W_LINES),
        .W_HOLES  (W_HOLES),
        .W_BUMP   (W_BUMP),
        .W_HEIGHT (W_HEIGHT)
    ) u_score_calc (
        .lines_cleared (lines_cleared),
        .holes         (holes),
        .bumpiness     (bumpiness),
        .height_sum    (height_sum),
        .best_valid    (best_valid_q),
        .best_score    (best_score_q),
        .score         (score),
        .better        (better)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d      = state_q;
        rot_d        = rot_q;
        col_d        = col_q;
        best_valid_d = best_valid_q;
        best_rot_d   = best_rot_q;
        best_col_d   = best_col_q;
        best_score_d = best_score_q;

        case (state_q)
            S_IDLE: begin
                if (start_search && !abort) begin
                    best_valid_d = 1'b0;
                    best_rot_d   = '0;
                    best_col_d   = '0;
                    best_score_d = '0;
                    rot_d        = '0;
                    col_d        = '0;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                if (place_req_q && place_ack) begin
                    state_d = place_legal ? S_START : S_NEXT;
                end
            end
            S_START:     state_d = S_WAIT_LOW;
            // A ready left high by the previous run must be seen low first.
            S_WAIT_LOW:  if (!extract_ready) state_d = S_WAIT_HIGH;
            S_WAIT_HIGH: if (extract_ready)  state_d = S_SCORE;
            S_SCORE: begin
                if (better) begin
                    best_valid_d = 1'b1;
                    best_rot_d   = rot_q;
                    best_col_d   = col_q;
                    best_score_d = score;
                end
                state_d = S_RELEASE;
            end
            S_RELEASE:   state_d = S_NEXT;
            S_NEXT: begin
                if (col_q == COL_LAST) begin
                    col_d   = '0;
                    rot_d   = rot_q + ROT_W'(1);
                    state_d = (rot_q == ROT_LAST) ? S_DONE : S_REQ;
                end else begin
                    col_d   = col_q + COL_W'(1);
                    state_d = S_REQ;
                end
            end
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            best_valid_d = 1'b0;
        end

        // Outputs are decoded from the next state so they leave a flop.
        place_req_d     = (state_d == S_REQ);
        start_extract_d = (state_d inside {S_START, S_WAIT_LOW, S_WAIT_HIGH, S_SCORE});
        busy_d          = (state_d != S_IDLE);
        search_done_d   = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            rot_q           <= '0;
            col_q           <= '0;
            place_req_q     <= 1'b0;
            start_extract_q <= 1'b0;
            busy_q          <= 1'b0;
            search_done_q   <= 1'b0;
            best_valid_q    <= 1'b0;
            best_rot_q      <= '0;
            best_col_q      <= '0;
            best_score_q    <= '0;
        end else begin
            state_q         <= state_d;
            rot_q           <= rot_d;
            col_q           <= col_d;
            place_req_q     <= place_req_d;
            start_extract_q <= start_extract_d;
            busy_q          <= busy_d;
            search_done_q   <= search_done_d;
            best_valid_q    <= best_valid_d;
            best_rot_q      <= best_rot_d;
            best_col_q      <= best_col_d;
            best_score_q    <= best_score_d;
        end
    end

    assign place_req     = place_req_q;
    assign place_rot     = rot_q;
    assign place_col     = col_q;
    assign start_extract = start_extract_q;
    assign busy          = busy_q;
    assign search_done   = search_done_q;
    assign best_valid    = best_valid_q;
    assign best_rot      = best_rot_q;
    assign best_col      = best_col_q;
    assign best_score    = best_score_q;

endmodule

// File: tb/tb_t01_ai_move_scheduler.sv
// Directed bench for the AI move scheduler with behavioural placement
// generator and feature extractor models driven from feature tables.
module tb_t01_ai_move_scheduler;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start_search;
    logic               abort;
    logic               place_req;
    logic        [1:0]  place_rot;
    logic        [3:0]  place_col;
    logic               place_ack;
    logic               place_legal;
    logic               start_extract;
    logic               extract_ready;
    logic        [2:0]  lines_cleared;
    logic        [7:0]  holes;
    logic        [7:0]  bumpiness;
    logic        [7:0]  height_sum;
    logic               busy;
    logic               search_done;
    logic               best_valid;
    logic        [1:0]  best_rot;
    logic        [3:0]  best_col;
    logic signed [15:0] best_score;

    int checks = 0;
    int errors = 0;

    // Candidate tables consulted by the models
    bit         legal_t  [4][10];
    logic [2:0] lines_t  [4][10];
    logic [7:0] holes_t  [4][10];
    logic [7:0] bump_t   [4][10];
    logic [7:0] height_t [4][10];
    int         stop_col = 15;
    bit         ex_stale = 1'b0;
    int         ex_st    = 0;
    int         ex_cnt   = 0;

    t01_ai_move_scheduler dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start_search  (start_search),
        .abort         (abort),
        .place_req     (place_req),
        .place_rot     (place_rot),
        .place_col     (place_col),
        .place_ack     (place_ack),
        .place_legal   (place_legal),
        .start_extract (start_extract),
        .extract_ready (extract_ready),
        .lines_cleared (lines_cleared),
        .holes         (holes),
        .bumpiness     (bumpiness),
        .height_sum    (height_sum),
        .busy          (busy),
        .search_done   (search_done),
        .best_valid    (best_valid),
        .best_rot      (best_rot),
        .best_col      (best_col),
        .best_score    (best_score)
    );

    always #5 clk = ~clk;

    // Placement generator: ack one cycle after a request, legality from table.
    initial begin
        place_ack   = 1'b0;
        place_legal = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (place_req && !place_ack && (int'(place_col) < stop_col)) begin
                place_ack   = 1'b1;
                place_legal = legal_t[place_rot][place_col];
            end else begin
                place_ack   = 1'b0;
                place_legal = 1'b0;
            end
        end
    end

    // Extractor: idle / busy 6 cycles / hold result until start drops.
    // In stale mode ready idles high with garbage features (score 56).
    initial begin
        extract_ready = 1'b0;
        lines_cleared = '0;
        holes         = '0;
        bumpiness     = '0;
        height_sum    = '0;
        forever begin
            @(posedge clk);
            #1;
            case (ex_st)
                0: begin
                    if (start_extract) begin
                        ex_cnt = 0;
                        ex_st  = 1;
                    end else begin
                        extract_ready = ex_stale;
                        if (ex_stale) begin
                            lines_cleared = 3'd7;
                            holes = '0; bumpiness = '0; height_sum = '0;
                        end
                    end
                end
                1: begin
                    ex_cnt++;
                    if (ex_cnt >= 2) extract_ready = 1'b0;
                    if (ex_cnt == 6) begin
                        lines_cleared = lines_t[place_rot][place_col];
                        holes         = holes_t[place_rot][place_col];
                        bumpiness     = bump_t[place_rot][place_col];
                        height_sum    = height_t[place_rot][place_col];
                        extract_ready = 1'b1;
                        ex_st         = 2;
                    end
                end
                default: begin
                    if (!start_extract) begin
                        ex_st         = 0;
                        extract_ready = ex_stale;
                        if (ex_stale) begin
                            lines_cleared = 3'd7;
                            holes = '0; bumpiness = '0; height_sum = '0;
                        end
                    end
                end
            endcase
        end
    end

    task automatic fill_tables(input bit legal);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 10; c++) begin
                legal_t[r][c]  = legal;
                lines_t[r][c]  = '0;
                holes_t[r][c]  = '0;
                bump_t[r][c]   = '0;
                height_t[r][c] = '0;
            end
        end
    endtask

    // Pulse start, wait for search_done (bounded), count pulses a few cycles past it.
    task automatic run_search(output int pulses, output bit ext_seen);
        bit done_seen;
        done_seen = 1'b0;
        pulses    = 0;
        ext_seen  = 1'b0;
        @(negedge clk) start_search = 1'b1;
        @(negedge clk) start_search = 1'b0;
        for (int i = 0; i < 3000 && !done_seen; i++) begin
            @(negedge clk);
            if (start_extract) ext_seen = 1'b1;
            if (search_done) begin
                done_seen = 1'b1;
                pulses++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (search_done) pulses++;
        end
        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL search_timeout: search_done got 0 want 1 within 3000 cycles");
        end
    endtask

    task automatic check_best(input string name, input bit v, input logic [1:0] r,
                              input logic [3:0] c, input logic signed [15:0] s);
        checks++;
        if ({best_valid, best_rot, best_col, best_score} !== {v, r, c, s}) begin
            errors++;
            $display("FAIL %s best: got valid=%0d rot=%0d col=%0d score=%0d want valid=%0d rot=%0d col=%0d score=%0d",
                     name, best_valid, best_rot, best_col, best_score, v, r, c, s);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start_search = 1'b0; abort = 1'b0;
        fill_tables(1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if ({place_req, place_rot, place_col, start_extract, busy, search_done,
             best_valid, best_rot, best_col, best_score} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs want all 0");
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %0d want 0", busy);
        end
    endtask

    task automatic test_single_winner();
        int pulses; bit ext;
        fill_tables(1'b1);
        lines_t[2][7] = 3'd2;
        lines_t[3][1] = 3'd2;
        run_search(pulses, ext);
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL winner_done_pulses: got %0d want 1", pulses);
        end
        check_best("winner", 1'b1, 2'd2, 4'd7, 16'sd16);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL winner_busy_after: got %0d want 0", busy);
        end
    endtask

    task automatic test_ties();
        int pulses; bit ext;
        fill_tables(1'b1);
        run_search(pulses, ext);
        check_best("ties", 1'b1, 2'd0, 4'd0, 16'sd0);
    endtask

    task automatic test_negative();
        int pulses; bit ext;
        fill_tables(1'b0);
        legal_t[1][3]  = 1'b1;
        lines_t[1][3]  = 3'd1;
        holes_t[1][3]  = 8'd2;
        bump_t[1][3]   = 8'd3;
        height_t[1][3] = 8'd10;
        run_search(pulses, ext);
        check_best("negative", 1'b1, 2'd1, 4'd3, -16'sd15);
    endtask

    task automatic test_all_illegal();
        int pulses; bit ext;
        fill_tables(1'b0);
        run_search(pulses, ext);
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL illegal_done_pulses: got %0d want 1", pulses);
        end
        check_best("illegal", 1'b0, 2'd0, 4'd0, 16'sd0);
        checks++;
        if (ext !== 1'b0) begin
            errors++;
            $display("FAIL illegal_start_extract: got %0d want 0", ext);
        end
    endtask

    task automatic test_stale_ready();
        int pulses; bit ext;
        fill_tables(1'b1);
        lines_t[0][5] = 3'd1;
        ex_stale = 1'b1;
        repeat (3) @(negedge clk);
        run_search(pulses, ext);
        ex_stale = 1'b0;
        repeat (3) @(negedge clk);
        check_best("stale", 1'b1, 2'd0, 4'd5, 16'sd8);
    endtask

    task automatic test_abort();
        bit reached, done_seen;
        fill_tables(1'b1);
        stop_col = 3;
        reached  = 1'b0;
        @(negedge clk) start_search = 1'b1;
        @(negedge clk) start_search = 1'b0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(negedge clk);
            if (place_req && place_col == 4'd3) reached = 1'b1;
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL abort_reach_req: got col=%0d want REQ at col 3", place_col);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (best_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_valid: got %0d want 1", best_valid);
        end
        start_search = 1'b1;
        @(negedge clk) start_search = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, place_req, place_col} !== {1'b1, 1'b1, 4'd3}) begin
            errors++;
            $display("FAIL busy_start_ignored: got busy=%0d req=%0d col=%0d want 1 1 3",
                     busy, place_req, place_col);
        end
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        checks++;
        if ({busy, place_req, start_extract, best_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_outputs: got busy=%0d req=%0d ext=%0d valid=%0d want 0 0 0 0",
                     busy, place_req, start_extract, best_valid);
        end
        done_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (search_done) done_seen = 1'b1;
        end
        stop_col = 15;
        checks++;
        if (done_seen !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got done=%0d busy=%0d want 0 0", done_seen, busy);
        end
        abort = 1'b1; start_search = 1'b1;
        @(negedge clk) begin abort = 1'b0; start_search = 1'b0; end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_beats_start: got busy=%0d want 0", busy);
        end
    endtask

    task automatic test_reset_mid_search();
        bit reached, done_seen;
        fill_tables(1'b1);
        reached = 1'b0;
        @(negedge clk) start_search = 1'b1;
        @(negedge clk) start_search = 1'b0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(negedge clk);
            if (place_col == 4'd2 && ex_st == 1 && ex_cnt == 4) reached = 1'b1;
        end
        checks++;
        if (!reached || best_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_reach: got reached=%0d valid=%0d want 1 1", reached, best_valid);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({place_req, place_rot, place_col, start_extract, busy, search_done,
             best_valid, best_rot, best_col, best_score} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got busy=%0d ext=%0d valid=%0d col=%0d want all 0",
                     busy, start_extract, best_valid, place_col);
        end
        @(negedge clk) reset_n = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (search_done) done_seen = 1'b1;
        end
        checks++;
        if (done_seen !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: got done=%0d busy=%0d want 0 0", done_seen, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_winner();
        test_ties();
        test_negative();
        test_all_illegal();
        test_stale_ready();
        test_abort();
        test_reset_mid_search();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
